mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 32, address width.
REQ-002 Parameter DATA_W, default 32, maximum transfer width in bits (4 bytes).
REQ-003 clk_in  input  1  sole clock; all state changes on rising edge.
REQ-004 rst_in  input  1  reset, asynchronous, active-low.
REQ-005 rdy_in  input  1  global enable; low freezes all state.
REQ-006 flush_in  input  1  misprediction flush from commit logic.
REQ-007 if_en_in  input  1  fetch request, held until if_done_out.
REQ-008 if_addr_in  input  ADDR_W  fetch address; always 4 bytes.
REQ-009 if_done_out  output  1  one-cycle fetch-complete pulse.
REQ-010 if_data_out  output  32  fetched word, little-endian.
REQ-011 lb_en_in / lb_addr_in / lb_width_in  input  1/ADDR_W/3  load request; width 3'b001, 3'b010 or 3'b100 bytes.
REQ-012 lb_done_out / lb_data_out  output  1/32  load-complete pulse; data zero-extended.
REQ-013 st_en_in / st_addr_in / st_width_in / st_data_in  input  1/ADDR_W/3/32  committed-store request; width encoded as for loads.
REQ-014 st_done_out  output  1  one-cycle store-complete pulse.
REQ-015 mem_din_in  input  8  RAM read byte; valid one cycle after RAM samples mem_a_out.
REQ-016 mem_dout_out / mem_a_out / mem_wr_out  output  8/ADDR_W/1  RAM write byte, address, write strobe (1 = write).

Function
REQ-017 All outputs shall be registered.
REQ-018 Each requester shall hold en and arguments stable until its done pulse and drop en the cycle after.
REQ-019 The FSM shall have states IDLE, READ and WRITE.
REQ-020 Grant in IDLE shall use fixed priority: store > load > fetch; arguments are latched at the grant edge E0.
REQ-021 WRITE: byte k (k = 0..N-1) = st_data_in[8k+7:8k] is driven to address addr+k with mem_wr_out = 1 at edge E0+k.
REQ-022 WRITE: at edge E0+N, mem_wr_out is cleared, st_done_out pulses, and the FSM returns to IDLE.
REQ-023 READ: address addr+k is issued at edge E0+k with mem_wr_out = 0.
REQ-024 READ: mem_din_in is captured into byte k at edge E0+k+2.
REQ-025 READ: the done pulse and data are presented at edge E0+N+1, then the FSM returns to IDLE.
REQ-026 Address arithmetic shall wrap modulo 2^ADDR_W.
REQ-027 A new grant is allowed no earlier than the edge following return to IDLE, so at least one idle cycle separates transactions.
REQ-028 Flush during READ shall abort the read: next edge to IDLE, no done pulse, captured bytes discarded.
REQ-029 Flush during WRITE shall be ignored; the store completes.
REQ-030 While flush_in is high, IDLE shall grant only store requests.
REQ-031 When rdy_in = 0, state, counter and outputs shall hold; done pulses do not repeat on resume.
REQ-032 At most one done output shall be high in any cycle.
REQ-033 An illegal width (not 1/2/4) shall be treated as 4.

Reset
REQ-034 On rst_in low, asynchronously: state = IDLE, counter = 0.
REQ-035 On rst_in low, asynchronously: mem_wr_out = 0, mem_a_out = 0, mem_dout_out = 0.
REQ-036 On rst_in low, asynchronously: all done outputs = 0 and all data outputs = 0.
REQ-037 Reset mid-transaction shall drop that transaction without a done pulse; the requester reissues it.

Structure
REQ-038 Width encodings, ADDR_W and the state encodings belong in the shared constant.vh package.
REQ-039 The design shall be a single module; no sub-module is warranted.

Verification
REQ-040 Scenario: SW 0xDEADBEEF to 0x100 -> writes EF, BE, AD, DE to 0x100..0x103 at E0..E3; st_done_out pulses at E4.
REQ-041 Scenario: fetch 0x0 with RAM bytes 13, 05, 00, 00 -> if_data_out = 0x00000513; if_done_out pulses at E0+5.
REQ-042 Scenario: store, load and fetch raised in the same cycle -> serviced in order store, load, fetch, one done pulse each.
REQ-043 Scenario: LB 0x200, width 1, flush_in asserted at E0+1 -> no lb_done_out; FSM in IDLE at E0+2.
REQ-044 Scenario: rdy_in low for 3 cycles during a 2-byte store -> mem_a_out holds; exactly 2 bytes written; one st_done_out.
REQ-045 Scenario: rst_in low mid-READ -> all outputs 0 immediately; after release, the next request is serviced normally.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// mem_arbiter_pkg
// Shared constants for the byte-serial memory arbiter: default bus widths,
// access-width encodings, FSM state encoding, requester identifiers and the
// small byte-manipulation helpers used by the arbiter datapath.
// ---------------------------------------------------------------------------
package mem_arbiter_pkg;

    // Default address width and maximum transfer width in bits.
    localparam int ADDR_W_DEFAULT = 32;
    localparam int DATA_W_DEFAULT = 32;

    // Access-width encodings shared by loads and stores (value = byte count).
    localparam logic [2:0] WIDTH_BYTE = 3'b001;
    localparam logic [2:0] WIDTH_HALF = 3'b010;
    localparam logic [2:0] WIDTH_WORD = 3'b100;

    // Arbiter FSM states.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_READ  = 2'b01,
        ST_WRITE = 2'b10
    } arb_state_t;

    // Which requester owns the current transaction.
    typedef enum logic [1:0] {
        REQ_NONE  = 2'b00,
        REQ_STORE = 2'b01,
        REQ_LOAD  = 2'b10,
        REQ_FETCH = 2'b11
    } req_kind_t;

    // Number of bytes for a width encoding; anything unrecognised is a word.
    function automatic logic [2:0] width_bytes(input logic [2:0] width);
        logic [2:0] n;
        case (width)
            WIDTH_BYTE: n = 3'd1;
            WIDTH_HALF: n = 3'd2;
            WIDTH_WORD: n = 3'd4;
            default:    n = 3'd4;
        endcase
        return n;
    endfunction

    // Extract little-endian byte idx of a 32-bit word.
    function automatic logic [7:0] pick_byte(input logic [31:0] data,
                                             input logic [1:0]  idx);
        logic [7:0] b;
        case (idx)
            2'd0:    b = data[7:0];
            2'd1:    b = data[15:8];
            2'd2:    b = data[23:16];
            2'd3:    b = data[31:24];
            default: b = 8'h00;
        endcase
        return b;
    endfunction

    // Replace little-endian byte idx of a 32-bit word.
    function automatic logic [31:0] put_byte(input logic [31:0] data,
                                             input logic [1:0]  idx,
                                             input logic [7:0]  b);
        logic [31:0] r;
        r = data;
        case (idx)
            2'd0:    r[7:0]   = b;
            2'd1:    r[15:8]  = b;
            2'd2:    r[23:16] = b;
            2'd3:    r[31:24] = b;
            default: r = data;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/mem_arbiter.sv
// ---------------------------------------------------------------------------
// mem_arbiter
// Arbitrates instruction fetch, data load and committed store requests onto
// a single byte-wide synchronous RAM port. One byte moves per cycle; reads
// see the RAM byte two edges after the address is issued.
//
// Ports
//   clk_in, rst_in (async, active-low), rdy_in (global enable)
//   flush_in                       : misprediction flush
//   if_en_in/if_addr_in            : fetch request (always one word)
//   if_done_out/if_data_out        : fetch complete pulse / fetched word
//   lb_en_in/lb_addr_in/lb_width_in: load request (1, 2 or 4 bytes)
//   lb_done_out/lb_data_out        : load complete pulse / zero-extended data
//   st_en_in/st_addr_in/st_width_in/st_data_in : store request
//   st_done_out                    : store complete pulse
//   mem_din_in                     : RAM read byte
//   mem_dout_out/mem_a_out/mem_wr_out : RAM write byte, address, write strobe
// All outputs come straight from flops.
// ---------------------------------------------------------------------------
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEFAULT,
    parameter int DATA_W = DATA_W_DEFAULT
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              rdy_in,
    input  logic              flush_in,

    input  logic              if_en_in,
    input  logic [ADDR_W-1:0] if_addr_in,
    output logic              if_done_out,
    output logic [DATA_W-1:0] if_data_out,

    input  logic              lb_en_in,
    input  logic [ADDR_W-1:0] lb_addr_in,
    input  logic [2:0]        lb_width_in,
    output logic              lb_done_out,
    output logic [DATA_W-1:0] lb_data_out,

    input  logic              st_en_in,
    input  logic [ADDR_W-1:0] st_addr_in,
    input  logic [2:0]        st_width_in,
    input  logic [DATA_W-1:0] st_data_in,
    output logic              st_done_out,

    input  logic [7:0]        mem_din_in,
    output logic [7:0]        mem_dout_out,
    output logic [ADDR_W-1:0] mem_a_out,
    output logic              mem_wr_out
);

    arb_state_t        state_r;
    req_kind_t         kind_r;
    logic [2:0]        cnt_r;      // edges elapsed since the grant edge
    logic [2:0]        nbytes_r;   // bytes in the current transaction
    logic [ADDR_W-1:0] addr_r;
    logic [DATA_W-1:0] wdata_r;
    logic [DATA_W-1:0] rbuf_r;     // read bytes captured so far

    req_kind_t         grant_s;
    logic [1:0]        cap_idx_s;
    logic [DATA_W-1:0] rd_final_s;

    // Fixed-priority grant decode. A requester whose done pulse is still
    // showing is skipped so a lingering enable cannot start a duplicate.
    // During a flush only the committed store may proceed.
    always_comb begin
        grant_s = REQ_NONE;
        if (st_en_in && !st_done_out) begin
            grant_s = REQ_STORE;
        end else if (!flush_in && lb_en_in && !lb_done_out) begin
            grant_s = REQ_LOAD;
        end else if (!flush_in && if_en_in && !if_done_out) begin
            grant_s = REQ_FETCH;
        end else begin
            grant_s = REQ_NONE;
        end
    end

    // Read assembly: the byte arriving now belongs to index cnt-2 (mod 4),
    // so the final edge can present the word including the last byte.
    always_comb begin
        cap_idx_s  = cnt_r[1:0] - 2'd2;
        rd_final_s = rbuf_r;
        if (cnt_r >= 3'd2) begin
            rd_final_s = put_byte(rbuf_r, cap_idx_s, mem_din_in);
        end else begin
            rd_final_s = rbuf_r;
        end
    end

    // Arbiter FSM with registered RAM port and completion outputs.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_r      <= ST_IDLE;
            kind_r       <= REQ_NONE;
            cnt_r        <= 3'd0;
            nbytes_r     <= 3'd0;
            addr_r       <= {ADDR_W{1'b0}};
            wdata_r      <= {DATA_W{1'b0}};
            rbuf_r       <= {DATA_W{1'b0}};
            mem_wr_out   <= 1'b0;
            mem_a_out    <= {ADDR_W{1'b0}};
            mem_dout_out <= 8'h00;
            if_done_out  <= 1'b0;
            lb_done_out  <= 1'b0;
            st_done_out  <= 1'b0;
            if_data_out  <= {DATA_W{1'b0}};
            lb_data_out  <= {DATA_W{1'b0}};
        end else if (rdy_in) begin
            // Done outputs are single-cycle pulses.
            if_done_out <= 1'b0;
            lb_done_out <= 1'b0;
            st_done_out <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    mem_wr_out <= 1'b0;
                    cnt_r      <= 3'd0;
                    case (grant_s)
                        REQ_STORE: begin
                            state_r      <= ST_WRITE;
                            kind_r       <= REQ_STORE;
                            addr_r       <= st_addr_in;
                            wdata_r      <= st_data_in;
                            nbytes_r     <= width_bytes(st_width_in);
                            cnt_r        <= 3'd1;
                            // Byte 0 goes out on the grant edge itself.
                            mem_a_out    <= st_addr_in;
                            mem_dout_out <= pick_byte(st_data_in, 2'd0);
                            mem_wr_out   <= 1'b1;
                        end
                        REQ_LOAD: begin
                            state_r   <= ST_READ;
                            kind_r    <= REQ_LOAD;
                            addr_r    <= lb_addr_in;
                            nbytes_r  <= width_bytes(lb_width_in);
                            cnt_r     <= 3'd1;
                            rbuf_r    <= {DATA_W{1'b0}};
                            mem_a_out <= lb_addr_in;
                        end
                        REQ_FETCH: begin
                            state_r   <= ST_READ;
                            kind_r    <= REQ_FETCH;
                            addr_r    <= if_addr_in;
                            nbytes_r  <= 3'd4;
                            cnt_r     <= 3'd1;
                            rbuf_r    <= {DATA_W{1'b0}};
                            mem_a_out <= if_addr_in;
                        end
                        default: begin
                            kind_r <= REQ_NONE;
                        end
                    endcase
                end

                ST_WRITE: begin
                    // A flush cannot touch a committed store.
                    if (cnt_r == nbytes_r) begin
                        mem_wr_out  <= 1'b0;
                        st_done_out <= 1'b1;
                        state_r     <= ST_IDLE;
                        kind_r      <= REQ_NONE;
                        cnt_r       <= 3'd0;
                    end else begin
                        mem_a_out    <= addr_r + ADDR_W'(cnt_r);
                        mem_dout_out <= pick_byte(wdata_r, cnt_r[1:0]);
                        mem_wr_out   <= 1'b1;
                        cnt_r        <= cnt_r + 3'd1;
                    end
                end

                ST_READ: begin
                    mem_wr_out <= 1'b0;
                    if (flush_in) begin
                        // Abandon the read; partial bytes are thrown away.
                        state_r <= ST_IDLE;
                        kind_r  <= REQ_NONE;
                        cnt_r   <= 3'd0;
                        rbuf_r  <= {DATA_W{1'b0}};
                    end else begin
                        if (cnt_r < nbytes_r) begin
                            mem_a_out <= addr_r + ADDR_W'(cnt_r);
                        end
                        if (cnt_r >= 3'd2) begin
                            rbuf_r <= rd_final_s;
                        end
                        if (cnt_r == nbytes_r + 3'd1) begin
                            case (kind_r)
                                REQ_LOAD: begin
                                    lb_done_out <= 1'b1;
                                    lb_data_out <= rd_final_s;
                                end
                                REQ_FETCH: begin
                                    if_done_out <= 1'b1;
                                    if_data_out <= rd_final_s;
                                end
                                default: begin
                                    lb_done_out <= 1'b0;
                                end
                            endcase
                            state_r <= ST_IDLE;
                            kind_r  <= REQ_NONE;
                            cnt_r   <= 3'd0;
                        end else begin
                            cnt_r <= cnt_r + 3'd1;
                        end
                    end
                end

                default: begin
                    state_r    <= ST_IDLE;
                    kind_r     <= REQ_NONE;
                    cnt_r      <= 3'd0;
                    mem_wr_out <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_arbiter
// Directed bench for mem_arbiter with a byte-wide synchronous RAM model.
// ---------------------------------------------------------------------------
module tb_mem_arbiter;
    import mem_arbiter_pkg::*;

    localparam int AW = 32;
    localparam int DW = 32;

    logic          clk_in   = 1'b0;
    logic          rst_in   = 1'b0;
    logic          rdy_in   = 1'b1;
    logic          flush_in = 1'b0;
    logic          if_en_in = 1'b0;
    logic [AW-1:0] if_addr_in = 32'h0;
    logic          if_done_out;
    logic [DW-1:0] if_data_out;
    logic          lb_en_in = 1'b0;
    logic [AW-1:0] lb_addr_in = 32'h0;
    logic [2:0]    lb_width_in = 3'b001;
    logic          lb_done_out;
    logic [DW-1:0] lb_data_out;
    logic          st_en_in = 1'b0;
    logic [AW-1:0] st_addr_in = 32'h0;
    logic [2:0]    st_width_in = 3'b001;
    logic [DW-1:0] st_data_in = 32'h0;
    logic          st_done_out;
    logic [7:0]    mem_din_in;
    logic [7:0]    mem_dout_out;
    logic [AW-1:0] mem_a_out;
    logic          mem_wr_out;

    int n_cmp = 0;
    int n_err = 0;

    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .flush_in(flush_in),
        .if_en_in(if_en_in), .if_addr_in(if_addr_in),
        .if_done_out(if_done_out), .if_data_out(if_data_out),
        .lb_en_in(lb_en_in), .lb_addr_in(lb_addr_in), .lb_width_in(lb_width_in),
        .lb_done_out(lb_done_out), .lb_data_out(lb_data_out),
        .st_en_in(st_en_in), .st_addr_in(st_addr_in), .st_width_in(st_width_in),
        .st_data_in(st_data_in), .st_done_out(st_done_out),
        .mem_din_in(mem_din_in), .mem_dout_out(mem_dout_out),
        .mem_a_out(mem_a_out), .mem_wr_out(mem_wr_out)
    );

    always #5 clk_in = ~clk_in;

    // Synchronous byte RAM: samples the address each edge, data valid next cycle.
    logic [7:0] ram [0:1023];
    logic [7:0] ram_q;
    always @(posedge clk_in) begin
        if (mem_wr_out) ram[mem_a_out[9:0]] <= mem_dout_out;
        ram_q <= ram[mem_a_out[9:0]];
    end
    assign mem_din_in = ram_q;

    task automatic tick;
        @(posedge clk_in);
        #1;
    endtask

    // Preload helper: runs one store to completion.
    task automatic do_store(input logic [31:0] a, input logic [2:0] w, input logic [31:0] d);
        int nb;
        nb = (w == 3'b001) ? 1 : (w == 3'b010) ? 2 : 4;
        st_en_in = 1'b1; st_addr_in = a; st_width_in = w; st_data_in = d;
        tick;
        repeat (nb) tick;
        st_en_in = 1'b0;
        tick;
    endtask

    task automatic test_reset;
        rst_in = 1'b0;
        tick; tick;
        n_cmp++; if (mem_a_out !== 32'h0) begin n_err++; $display("FAIL reset_mem_a: got %h want 0", mem_a_out); end
        n_cmp++; if (mem_wr_out !== 1'b0) begin n_err++; $display("FAIL reset_mem_wr: got %b want 0", mem_wr_out); end
        n_cmp++; if (mem_dout_out !== 8'h0) begin n_err++; $display("FAIL reset_mem_dout: got %h want 0", mem_dout_out); end
        n_cmp++; if ({if_done_out, lb_done_out, st_done_out} !== 3'b000) begin n_err++; $display("FAIL reset_dones: got %b want 000", {if_done_out, lb_done_out, st_done_out}); end
        n_cmp++; if (if_data_out !== 32'h0 || lb_data_out !== 32'h0) begin n_err++; $display("FAIL reset_data: got %h/%h want 0/0", if_data_out, lb_data_out); end
        rst_in = 1'b1;
        tick;
    endtask

    task automatic test_store_word;
        logic [7:0] exp_b [4];
        exp_b = '{8'hEF, 8'hBE, 8'hAD, 8'hDE};
        st_en_in = 1'b1; st_addr_in = 32'h100; st_width_in = 3'b100; st_data_in = 32'hDEADBEEF;
        for (int k = 0; k < 4; k++) begin
            tick;
            n_cmp++; if (mem_a_out !== 32'h100 + 32'(k)) begin n_err++; $display("FAIL store_addr[%0d]: got %h want %h", k, mem_a_out, 32'h100 + 32'(k)); end
            n_cmp++; if (mem_dout_out !== exp_b[k] || mem_wr_out !== 1'b1) begin n_err++; $display("FAIL store_byte[%0d]: got %h wr %b want %h wr 1", k, mem_dout_out, mem_wr_out, exp_b[k]); end
            n_cmp++; if (st_done_out !== 1'b0) begin n_err++; $display("FAIL store_early_done[%0d]: got %b want 0", k, st_done_out); end
        end
        tick;
        n_cmp++; if (st_done_out !== 1'b1 || mem_wr_out !== 1'b0) begin n_err++; $display("FAIL store_done: got done %b wr %b want 1 0", st_done_out, mem_wr_out); end
        st_en_in = 1'b0;
        tick;
        n_cmp++; if (st_done_out !== 1'b0) begin n_err++; $display("FAIL store_pulse_len: got %b want 0", st_done_out); end
    endtask

    task automatic test_fetch;
        do_store(32'h0, 3'b100, 32'h00000513);
        if_en_in = 1'b1; if_addr_in = 32'h0;
        for (int c = 0; c <= 5; c++) begin
            tick;
            if (c < 4) begin
                n_cmp++; if (mem_a_out !== 32'(c) || mem_wr_out !== 1'b0) begin n_err++; $display("FAIL fetch_addr[%0d]: got %h wr %b want %h wr 0", c, mem_a_out, mem_wr_out, 32'(c)); end
            end
            if (c < 5) begin
                n_cmp++; if (if_done_out !== 1'b0) begin n_err++; $display("FAIL fetch_early_done[%0d]: got %b want 0", c, if_done_out); end
            end else begin
                n_cmp++; if (if_done_out !== 1'b1) begin n_err++; $display("FAIL fetch_done: got %b want 1", if_done_out); end
                n_cmp++; if (if_data_out !== 32'h00000513) begin n_err++; $display("FAIL fetch_data: got %h want 00000513", if_data_out); end
            end
        end
        if_en_in = 1'b0;
        tick;
    endtask

    task automatic test_load_widths;
        logic [31:0] la [3];
        logic [2:0]  lw [3];
        logic [31:0] le [3];
        int          ln [3];
        la = '{32'h101, 32'h102, 32'h100};
        lw = '{3'b001, 3'b010, 3'b011};
        le = '{32'h000000BE, 32'h0000DEAD, 32'hDEADBEEF};
        ln = '{1, 2, 4};
        for (int t = 0; t < 3; t++) begin
            lb_en_in = 1'b1; lb_addr_in = la[t]; lb_width_in = lw[t];
            for (int c = 0; c <= ln[t] + 1; c++) begin
                tick;
                if (c <= ln[t]) begin
                    n_cmp++; if (lb_done_out !== 1'b0) begin n_err++; $display("FAIL load%0d_early_done[%0d]: got %b want 0", t, c, lb_done_out); end
                end else begin
                    n_cmp++; if (lb_done_out !== 1'b1 || lb_data_out !== le[t]) begin n_err++; $display("FAIL load%0d_data: got done %b data %h want 1 %h", t, lb_done_out, lb_data_out, le[t]); end
                end
            end
            lb_en_in = 1'b0;
            tick;
        end
    endtask

    task automatic test_priority;
        int order [3];
        int n_done = 0;
        int multi = 0;
        int st_cnt = 0, lb_cnt = 0, if_cnt = 0;
        logic [31:0] lb_val = 32'h0, if_val = 32'h0;
        order = '{-1, -1, -1};
        st_en_in = 1'b1; st_addr_in = 32'h104; st_width_in = 3'b100; st_data_in = 32'h11223344;
        lb_en_in = 1'b1; lb_addr_in = 32'h100; lb_width_in = 3'b100;
        if_en_in = 1'b1; if_addr_in = 32'h104;
        for (int cyc = 0; cyc < 40; cyc++) begin
            tick;
            if (int'(st_done_out) + int'(lb_done_out) + int'(if_done_out) > 1) multi++;
            if (st_done_out) begin st_cnt++; st_en_in = 1'b0; if (n_done < 3) order[n_done] = 0; n_done++; end
            if (lb_done_out) begin lb_cnt++; lb_en_in = 1'b0; lb_val = lb_data_out; if (n_done < 3) order[n_done] = 1; n_done++; end
            if (if_done_out) begin if_cnt++; if_en_in = 1'b0; if_val = if_data_out; if (n_done < 3) order[n_done] = 2; n_done++; end
        end
        st_en_in = 1'b0; lb_en_in = 1'b0; if_en_in = 1'b0;
        n_cmp++; if (st_cnt != 1 || lb_cnt != 1 || if_cnt != 1) begin n_err++; $display("FAIL prio_counts: got st %0d lb %0d if %0d want 1 1 1", st_cnt, lb_cnt, if_cnt); end
        n_cmp++; if (order[0] != 0 || order[1] != 1 || order[2] != 2) begin n_err++; $display("FAIL prio_order: got %0d %0d %0d want 0 1 2", order[0], order[1], order[2]); end
        n_cmp++; if (multi != 0) begin n_err++; $display("FAIL prio_onehot: got %0d overlapping cycles want 0", multi); end
        n_cmp++; if (lb_val !== 32'hDEADBEEF) begin n_err++; $display("FAIL prio_lb_data: got %h want deadbeef", lb_val); end
        n_cmp++; if (if_val !== 32'h11223344) begin n_err++; $display("FAIL prio_if_data: got %h want 11223344", if_val); end
        tick;
    endtask

    task automatic test_flush_read;
        lb_en_in = 1'b1; lb_addr_in = 32'h200; lb_width_in = 3'b001;
        tick;               // E0
        flush_in = 1'b1;
        tick;               // E0+1: read aborted
        n_cmp++; if (lb_done_out !== 1'b0) begin n_err++; $display("FAIL flush_done_e1: got %b want 0", lb_done_out); end
        tick;               // E0+2
        n_cmp++; if (dut.state_r !== ST_IDLE) begin n_err++; $display("FAIL flush_idle: got state %0d want %0d", dut.state_r, ST_IDLE); end
        for (int c = 0; c < 3; c++) begin
            tick;
            n_cmp++; if (lb_done_out !== 1'b0 || dut.state_r !== ST_IDLE) begin n_err++; $display("FAIL flush_hold[%0d]: got done %b state %0d want 0 %0d", c, lb_done_out, dut.state_r, ST_IDLE); end
        end
        // A store still gets through while the flush is held.
        st_en_in = 1'b1; st_addr_in = 32'h204; st_width_in = 3'b001; st_data_in = 32'h00000055;
        tick;
        n_cmp++; if (mem_wr_out !== 1'b1 || mem_a_out !== 32'h204 || mem_dout_out !== 8'h55) begin n_err++; $display("FAIL flush_store_grant: got wr %b a %h d %h want 1 204 55", mem_wr_out, mem_a_out, mem_dout_out); end
        tick;
        n_cmp++; if (st_done_out !== 1'b1) begin n_err++; $display("FAIL flush_store_done: got %b want 1", st_done_out); end
        st_en_in = 1'b0; lb_en_in = 1'b0; flush_in = 1'b0;
        tick;
    endtask

    task automatic test_rdy_stall;
        int done_cnt = 0;
        do_store(32'h300, 3'b100, 32'h33445566);
        st_en_in = 1'b1; st_addr_in = 32'h300; st_width_in = 3'b010; st_data_in = 32'h0000CAFE;
        tick;
        n_cmp++; if (mem_a_out !== 32'h300 || mem_dout_out !== 8'hFE || mem_wr_out !== 1'b1) begin n_err++; $display("FAIL stall_b0: got a %h d %h wr %b want 300 fe 1", mem_a_out, mem_dout_out, mem_wr_out); end
        rdy_in = 1'b0;
        for (int c = 0; c < 3; c++) begin
            tick;
            if (st_done_out) done_cnt++;
            n_cmp++; if (mem_a_out !== 32'h300 || mem_wr_out !== 1'b1) begin n_err++; $display("FAIL stall_hold[%0d]: got a %h wr %b want 300 1", c, mem_a_out, mem_wr_out); end
        end
        rdy_in = 1'b1;
        tick;
        if (st_done_out) done_cnt++;
        n_cmp++; if (mem_a_out !== 32'h301 || mem_dout_out !== 8'hCA) begin n_err++; $display("FAIL stall_b1: got a %h d %h want 301 ca", mem_a_out, mem_dout_out); end
        tick;
        if (st_done_out) done_cnt++;
        st_en_in = 1'b0;
        tick;
        if (st_done_out) done_cnt++;
        n_cmp++; if (done_cnt != 1) begin n_err++; $display("FAIL stall_done_count: got %0d want 1", done_cnt); end
        lb_en_in = 1'b1; lb_addr_in = 32'h300; lb_width_in = 3'b100;
        repeat (6) tick;
        n_cmp++; if (lb_done_out !== 1'b1 || lb_data_out !== 32'h3344CAFE) begin n_err++; $display("FAIL stall_readback: got done %b data %h want 1 3344cafe", lb_done_out, lb_data_out); end
        lb_en_in = 1'b0;
        tick;
    endtask

    task automatic test_reset_mid_read;
        if_en_in = 1'b1; if_addr_in = 32'h100;
        tick; tick; tick;   // E0..E0+2, READ in flight
        rst_in = 1'b0;
        #1;
        n_cmp++; if (mem_a_out !== 32'h0 || mem_wr_out !== 1'b0 || mem_dout_out !== 8'h0) begin n_err++; $display("FAIL midrst_mem: got a %h wr %b d %h want 0 0 0", mem_a_out, mem_wr_out, mem_dout_out); end
        n_cmp++; if ({if_done_out, lb_done_out, st_done_out} !== 3'b000 || if_data_out !== 32'h0 || lb_data_out !== 32'h0) begin n_err++; $display("FAIL midrst_out: got dones %b if %h lb %h want 000 0 0", {if_done_out, lb_done_out, st_done_out}, if_data_out, lb_data_out); end
        if_en_in = 1'b0;
        tick;
        rst_in = 1'b1;
        tick;
        if_en_in = 1'b1; if_addr_in = 32'h100;
        for (int c = 0; c <= 5; c++) begin
            tick;
            if (c < 5) begin
                n_cmp++; if (if_done_out !== 1'b0) begin n_err++; $display("FAIL midrst_early_done[%0d]: got %b want 0", c, if_done_out); end
            end else begin
                n_cmp++; if (if_done_out !== 1'b1 || if_data_out !== 32'hDEADBEEF) begin n_err++; $display("FAIL midrst_refetch: got done %b data %h want 1 deadbeef", if_done_out, if_data_out); end
            end
        end
        if_en_in = 1'b0;
        tick;
    endtask

    task automatic test_wrap;
        st_en_in = 1'b1; st_addr_in = 32'hFFFFFFFF; st_width_in = 3'b010; st_data_in = 32'h0000BBAA;
        tick;
        n_cmp++; if (mem_a_out !== 32'hFFFFFFFF || mem_dout_out !== 8'hAA) begin n_err++; $display("FAIL wrap_b0: got a %h d %h want ffffffff aa", mem_a_out, mem_dout_out); end
        tick;
        n_cmp++; if (mem_a_out !== 32'h0 || mem_dout_out !== 8'hBB) begin n_err++; $display("FAIL wrap_b1: got a %h d %h want 0 bb", mem_a_out, mem_dout_out); end
        tick;
        st_en_in = 1'b0;
        tick;
        lb_en_in = 1'b1; lb_addr_in = 32'hFFFFFFFF; lb_width_in = 3'b010;
        repeat (4) tick;
        n_cmp++; if (lb_done_out !== 1'b1 || lb_data_out !== 32'h0000BBAA) begin n_err++; $display("FAIL wrap_load: got done %b data %h want 1 0000bbaa", lb_done_out, lb_data_out); end
        lb_en_in = 1'b0;
        tick;
    endtask

    initial begin
        test_reset;
        test_store_word;
        test_fetch;
        test_load_widths;
        test_priority;
        test_flush_read;
        test_rdy_stall;
        test_reset_mid_read;
        test_wrap;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
